// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the five-stage WISC pipeline: merges memory
// handshakes, decode hazards, redirects and HALT draining into per-stage controls.
module pipeline_stall_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdu_stall,
    input  logic             br_taken_D,
    input  logic             halt_D,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    output logic             en_PC,
    output logic             en_FD,
    output logic             en_DX,
    output logic             en_XM,
    output logic             en_MW,
    output logic             flush_FD,
    output logic             bubble_DX,
    output logic             halt_out,
    output logic [CNT_W-1:0] cnt_hazard,
    output logic [CNT_W-1:0] cnt_mem
);

    localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_IMEM_WAIT = 3'd1,
        ST_DMEM_WAIT = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    state_t           state_r;
    logic             ret_drain_r;
    logic [DCW-1:0]   drain_cnt_r;
    logic             halt_out_r;
    logic [CNT_W-1:0] cnt_hazard_r;
    logic [CNT_W-1:0] cnt_mem_r;

    state_t eff_state_s;
    logic   halted_s;
    logic   freeze_s;
    logic   imem_miss_s;
    logic   hazard_s;
    logic   drain_s;

    // While frozen in DMEM_WAIT, the rest of the logic behaves as the state we came from
    always_comb begin
        eff_state_s = state_r;
        if (state_r == ST_DMEM_WAIT) begin
            eff_state_s = ret_drain_r ? ST_DRAIN : ST_RUN;
        end else begin
            eff_state_s = state_r;
        end
    end

    assign halted_s    = (state_r == ST_HALTED);
    assign freeze_s    = !halted_s && (dmem_stall || ((state_r == ST_DMEM_WAIT) && !dmem_done));
    assign imem_miss_s = !halted_s && !freeze_s &&
                         (imem_stall || ((state_r == ST_IMEM_WAIT) && !imem_done));
    assign hazard_s    = !halted_s && !freeze_s && !imem_miss_s && hdu_stall;
    assign drain_s     = !halted_s && !freeze_s && (eff_state_s == ST_DRAIN);

    // Per-stage enables and bubble/flush controls in priority order
    always_comb begin
        en_PC     = 1'b1;
        en_FD     = 1'b1;
        en_DX     = 1'b1;
        en_XM     = 1'b1;
        en_MW     = 1'b1;
        flush_FD  = 1'b0;
        bubble_DX = 1'b0;
        if (halted_s || freeze_s) begin
            en_PC = 1'b0;
            en_FD = 1'b0;
            en_DX = 1'b0;
            en_XM = 1'b0;
            en_MW = 1'b0;
        end else if (imem_miss_s) begin
            en_PC    = 1'b0;
            flush_FD = 1'b1;
        end else if (hazard_s) begin
            en_PC     = 1'b0;
            en_FD     = 1'b0;
            bubble_DX = 1'b1;
        end else if (drain_s) begin
            en_PC    = 1'b0;
            flush_FD = 1'b1;
        end else if (br_taken_D) begin
            flush_FD = 1'b1;
        end else begin
            flush_FD = 1'b0;
        end
    end

    // Sequencer state, drain countdown, halt flag and saturating stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            ret_drain_r  <= 1'b0;
            drain_cnt_r  <= {DCW{1'b0}};
            halt_out_r   <= 1'b0;
            cnt_hazard_r <= {CNT_W{1'b0}};
            cnt_mem_r    <= {CNT_W{1'b0}};
        end else begin
            if (freeze_s) begin
                state_r <= ST_DMEM_WAIT;
                if (state_r != ST_DMEM_WAIT) begin
                    ret_drain_r <= (state_r == ST_DRAIN);
                end
            end else if (halted_s) begin
                state_r <= ST_HALTED;
            end else if (drain_s) begin
                // The drain counter only moves on non-frozen cycles
                if (drain_cnt_r <= DCW'(1)) begin
                    state_r     <= ST_HALTED;
                    drain_cnt_r <= {DCW{1'b0}};
                    halt_out_r  <= 1'b1;
                end else begin
                    state_r     <= ST_DRAIN;
                    drain_cnt_r <= drain_cnt_r - DCW'(1);
                end
            end else if (imem_miss_s) begin
                state_r <= ST_IMEM_WAIT;
            end else if (!hdu_stall && !br_taken_D && halt_D) begin
                state_r     <= ST_DRAIN;
                drain_cnt_r <= DCW'(DRAIN_CYCLES);
            end else begin
                state_r <= ST_RUN;
            end

            if (hazard_s && (cnt_hazard_r != {CNT_W{1'b1}})) begin
                cnt_hazard_r <= cnt_hazard_r + CNT_W'(1);
            end
            if ((freeze_s || imem_miss_s) && (cnt_mem_r != {CNT_W{1'b1}})) begin
                cnt_mem_r <= cnt_mem_r + CNT_W'(1);
            end
        end
    end

    assign halt_out   = halt_out_r;
    assign cnt_hazard = cnt_hazard_r;
    assign cnt_mem    = cnt_mem_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (4-bit counters so saturation is reachable).
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;

    // control vector order: {en_PC, en_FD, en_DX, en_XM, en_MW, flush_FD, bubble_DX}
    localparam logic [6:0] C_IDLE  = 7'b1111100;
    localparam logic [6:0] C_HAZ   = 7'b0011101;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_FRZ   = 7'b0000000;
    localparam logic [6:0] C_IMEM  = 7'b0111110;
    localparam logic [6:0] C_DRAIN = 7'b0111110;

    // input vector order: {hdu, br, halt, imem_stall, imem_done, dmem_stall, dmem_done}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_HDU   = 7'b1000000;
    localparam logic [6:0] I_BR    = 7'b0100000;
    localparam logic [6:0] I_BRHDU = 7'b1100000;
    localparam logic [6:0] I_HALT  = 7'b0010000;
    localparam logic [6:0] I_IS    = 7'b0001000;
    localparam logic [6:0] I_ID    = 7'b0000100;
    localparam logic [6:0] I_DS    = 7'b0000010;
    localparam logic [6:0] I_DSIS  = 7'b0001010;
    localparam logic [6:0] I_DD    = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    logic hdu_stall, br_taken_D, halt_D, imem_stall, imem_done, dmem_stall, dmem_done;
    logic en_PC, en_FD, en_DX, en_XM, en_MW, flush_FD, bubble_DX, halt_out;
    logic [CW-1:0] cnt_hazard, cnt_mem;
    logic [6:0] ctl;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_stall_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .hdu_stall  (hdu_stall),
        .br_taken_D (br_taken_D),
        .halt_D     (halt_D),
        .imem_stall (imem_stall),
        .imem_done  (imem_done),
        .dmem_stall (dmem_stall),
        .dmem_done  (dmem_done),
        .en_PC      (en_PC),
        .en_FD      (en_FD),
        .en_DX      (en_DX),
        .en_XM      (en_XM),
        .en_MW      (en_MW),
        .flush_FD   (flush_FD),
        .bubble_DX  (bubble_DX),
        .halt_out   (halt_out),
        .cnt_hazard (cnt_hazard),
        .cnt_mem    (cnt_mem)
    );

    always #5 clk = ~clk;

    assign ctl = {en_PC, en_FD, en_DX, en_XM, en_MW, flush_FD, bubble_DX};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {hdu_stall, br_taken_D, halt_D, imem_stall, imem_done, dmem_stall, dmem_done} = v;
    endtask

    // apply inputs, check combinational controls at negedge, then step past the edge
    task automatic cyc(input string tag, input logic [6:0] v, input logic [6:0] exp);
        drive(v);
        @(negedge clk);
        check_eq(tag, {9'd0, ctl}, {9'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(I_NONE);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_halt", {15'd0, halt_out}, 16'd0);
        check_eq("rst_cnt_hazard", {12'd0, cnt_hazard}, 16'd0);
        check_eq("rst_cnt_mem", {12'd0, cnt_mem}, 16'd0);
        cyc("rst_idle", I_NONE, C_IDLE);

        // load-use and branch
        cyc("loaduse", I_HDU, C_HAZ);
        check_eq("loaduse_cnt", {12'd0, cnt_hazard}, 16'd1);
        cyc("after_loaduse", I_NONE, C_IDLE);
        cyc("branch", I_BR, C_BR);
        cyc("branch_vs_hdu", I_BRHDU, C_HAZ);
        check_eq("branch_hdu_cnt", {12'd0, cnt_hazard}, 16'd2);

        // dmem miss: 3 cycles driven high, 1 held by state, then done
        cyc("dmem_1", I_DS, C_FRZ);
        cyc("dmem_2_imem_overlap", I_DSIS, C_FRZ);
        cyc("dmem_3", I_DS, C_FRZ);
        cyc("dmem_hold", I_NONE, C_FRZ);
        cyc("dmem_done", I_DD, C_IDLE);
        check_eq("dmem_cnt", {12'd0, cnt_mem}, 16'd4);
        cyc("dmem_run", I_NONE, C_IDLE);

        // imem miss: 2 cycles driven, 1 held, then done loads FD
        cyc("imem_1", I_IS, C_IMEM);
        cyc("imem_2", I_IS, C_IMEM);
        cyc("imem_hold", I_NONE, C_IMEM);
        cyc("imem_done", I_ID, C_IDLE);
        check_eq("imem_cnt", {12'd0, cnt_mem}, 16'd7);
        cyc("imem_done_spurious", I_ID, C_IDLE);
        cyc("imem_after_spurious", I_NONE, C_IDLE);
        check_eq("hazard_cnt_kept", {12'd0, cnt_hazard}, 16'd2);

        // HALT with a 2-cycle dmem stall inside the drain
        do_reset();
        cyc("halt_decode", I_HALT, C_IDLE);
        cyc("drain_1", I_NONE, C_DRAIN);
        check_eq("drain_1_halt", {15'd0, halt_out}, 16'd0);
        cyc("drain_frz_1", I_DS, C_FRZ);
        cyc("drain_frz_2", I_DS, C_FRZ);
        cyc("drain_2_done", I_DD, C_DRAIN);
        check_eq("drain_2_halt", {15'd0, halt_out}, 16'd0);
        cyc("drain_3", I_NONE, C_DRAIN);
        check_eq("halted_flag", {15'd0, halt_out}, 16'd1);
        check_eq("drain_cnt_mem", {12'd0, cnt_mem}, 16'd2);
        cyc("halted_ctl", I_HDU, C_FRZ);
        check_eq("halted_no_hazard_cnt", {12'd0, cnt_hazard}, 16'd0);
        check_eq("halted_sticky", {15'd0, halt_out}, 16'd1);
        do_reset();
        check_eq("rst_clears_halt", {15'd0, halt_out}, 16'd0);
        cyc("rst_after_halt", I_NONE, C_IDLE);

        // reset mid-miss forgets the pending handshake
        cyc("miss_before_rst", I_IS, C_IMEM);
        do_reset();
        cyc("rst_mid_miss", I_NONE, C_IDLE);
        check_eq("rst_mid_miss_cnt", {12'd0, cnt_mem}, 16'd0);

        // saturation of the 4-bit hazard counter
        for (int i = 0; i < 14; i++) begin
            cyc("sat_fill", I_HDU, C_HAZ);
        end
        check_eq("sat_14", {12'd0, cnt_hazard}, 16'd14);
        for (int i = 0; i < 7; i++) begin
            cyc("sat_over", I_HDU, C_HAZ);
        end
        check_eq("sat_hold", {12'd0, cnt_hazard}, 16'h000F);
        drive(I_NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the five-stage WISC pipeline. Combines the decode-stage load-use/branch-operand stall, taken-branch/jump redirects, multi-cycle instruction- and data-memory handshakes, and HALT draining. From these it produces per-stage pipeline-register enables and bubble/flush controls. It also keeps saturating stall-cause counters for performance debug.

## Interface
- CNT_W, 16, width of each stall counter
- DRAIN_CYCLES, 3, cycles for HALT to travel from D to W after leaving decode
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hdu_stall  in  1  decode operand hazard stall (load-use, R7 link, branch/jump operand)
- br_taken_D  in  1  branch taken or jump resolved in decode this cycle
- halt_D  in  1  HALT decoded in D
- imem_stall  in  1  instruction memory busy (miss in progress)
- imem_done  in  1  instruction memory returns data this cycle
- dmem_stall  in  1  data memory busy for the access in M
- dmem_done  in  1  data memory completes this cycle
- en_PC, en_FD, en_DX, en_XM, en_MW  out  1 each  register load enables
- flush_FD  out  1  load NOP into IF/ID instead of fetched word
- bubble_DX  out  1  zero all control fields entering ID/EX
- halt_out  out  1  processor halted (held until reset)
- cnt_hazard  out  CNT_W  cycles stalled by hdu_stall
- cnt_mem  out  CNT_W  cycles stalled by imem or dmem

## Operation
- States: RUN, IMEM_WAIT, DMEM_WAIT, DRAIN, HALTED; encoded 3-bit, reset to RUN.
- Priority each cycle: dmem > imem > hdu_stall > br_taken_D > halt_D.
- Data-memory freeze (dmem_stall=1 or state DMEM_WAIT without dmem_done): all five enables 0, no flush/bubble. Enter DMEM_WAIT on dmem_stall. Return to RUN on dmem_done, or to DRAIN if DMEM_WAIT was entered from DRAIN. A pending imem miss is held.
- Instruction miss (imem_stall=1 or IMEM_WAIT without imem_done, no dmem freeze): en_PC=0, en_FD=1, flush_FD=1, en_DX/XM/MW=1, so the back end drains. Leave for RUN on imem_done; the fetched word loads into FD that cycle with flush_FD=0.
- Hazard stall (hdu_stall=1, no memory freeze): en_PC=0, en_FD=0, bubble_DX=1, en_DX/XM/MW=1. br_taken_D and halt_D are ignored that cycle.
- Taken branch (br_taken_D=1, no stall): all enables 1, flush_FD=1 to kill the wrong-path fetch.
- HALT (halt_D=1, no stall, state RUN): enter DRAIN with an internal drain counter loaded to DRAIN_CYCLES. In DRAIN: en_PC=0, flush_FD=1, other enables 1. The counter decrements each non-frozen cycle. At 0, go to HALTED.
- HALTED: all enables 0, halt_out=1; only rst exits.
- Counters: cnt_hazard +1 per cycle with hdu_stall effective (not overridden by memory). cnt_mem +1 per cycle of dmem freeze or imem stall. Both saturate at all-ones; no wrap.

## Timing
- Enables, flush_FD and bubble_DX are combinational from current state plus inputs, valid the same cycle.
- State, drain counter, halt_out and the stall counters are registered and update at posedge clk.
- Reset values: state RUN, halt_out 0, both counters 0, drain counter 0. With inputs idle after reset, all enables are 1 and flush/bubble are 0.
- rst mid-DRAIN, mid-miss, or in HALTED returns to RUN next edge; no pending handshake is remembered.
- dmem_done and imem_done in the same cycle: dmem exits first. The imem miss is re-evaluated next cycle from imem_stall.
- imem_done without a prior stall is ignored.

## Test plan
- Load-use: hdu_stall=1 one cycle -> en_PC=en_FD=0, bubble_DX=1, en_XM=1; cnt_hazard 0->1.
- Branch: br_taken_D=1 with hdu_stall=0 -> flush_FD=1, all enables 1. With hdu_stall=1 the same cycle -> flush_FD=0, bubble_DX=1.
- Dmem miss: dmem_stall high 4 cycles then dmem_done -> all enables 0 for 4 cycles, RUN after the done edge, cnt_mem=4. An overlapping imem_stall still gives a full freeze.
- Imem miss: imem_stall 3 cycles, imem_done -> en_PC=0, flush_FD=1, back end enabled; cnt_mem=3; FD loads on the done cycle.
- HALT: halt_D=1 -> DRAIN. A dmem stall of 2 cycles inside the drain extends it; halt_out=1 exactly DRAIN_CYCLES non-frozen cycles later. Asserting rst then clears halt_out and returns to RUN.
- Saturation: preload via 2^CNT_W+5 hazard cycles (CNT_W=4 build) -> cnt_hazard stays 4'hF.
